// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } ifetch_state_e;

    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifetch_pc_gen.sv
// PC register with next-PC selection (advance / hold / redirect) and redirect alignment check.
module ifetch_pc_gen
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic        misaligned
);

    logic [31:0] pc_next;

    assign misaligned = (redirect_target[1:0] != 2'b00);

    // A misaligned redirect leaves the PC untouched; the caller turns it into a fault.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            if (!misaligned) begin
                pc_next = redirect_target;
            end
        end else if (advance) begin
            pc_next = pc + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: FSM, IF/ID pipeline register and PC generator for a same-cycle instruction memory.
// Optional performance counters are enabled by defining IFETCH_PERF_CNT_EN.
module instruction_fetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        if_valid,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        misalign_fault
);

    ifetch_state_e state;
    logic [31:0]   pc;
    logic          misaligned;
    logic          in_run;
    logic          do_redirect;
    logic          do_advance;

    assign in_run      = (state == RUN);
    assign do_redirect = in_run && redirect_en;
    assign do_advance  = in_run && !redirect_en && !stall;
    assign imem_addr   = pc;

    ifetch_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk             (clk),
        .rst_n           (rst_n),
        .advance         (do_advance),
        .redirect        (do_redirect),
        .redirect_target (redirect_target),
        .pc              (pc),
        .misaligned      (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            if_instr       <= NOP_INSTR;
            if_pc          <= 32'd0;
            if_pc_plus4    <= 32'd0;
            if_valid       <= 1'b0;
            misalign_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if_valid <= 1'b0;
                    if_instr <= NOP_INSTR;
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Redirect flushes IF/ID even when stalled; if_pc/if_pc_plus4 keep old values.
                    if (redirect_en) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                        if (misaligned) begin
                            misalign_fault <= 1'b1;
                            state          <= FAULT;
                        end
                    end else if (!stall) begin
                        if_instr    <= imem_data;
                        if_pc       <= pc;
                        if_pc_plus4 <= pc + PC_STEP;
                        if_valid    <= 1'b1;
                    end
                end
                FAULT: begin
                    if_valid <= 1'b0;
                    if_instr <= NOP_INSTR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (do_advance) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (in_run && stall && !redirect_en) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit, plus a second instance for PC wrap.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, stall, redirect_en;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_data, if_instr, if_pc, if_pc_plus4;
    logic        if_valid, misalign_fault;

    logic        rst_n2, start2;
    logic [31:0] imem_addr2, imem_data2, if_instr2, if_pc2, if_pc_plus42;
    logic        if_valid2, misalign_fault2;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

    logic [31:0] mem [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_data  = mem[imem_addr[6:2]];
    assign imem_data2 = mem[imem_addr2[6:2]];

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stall           (stall),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_valid        (if_valid),
`ifdef IFETCH_PERF_CNT_EN
        .fetch_count     (fetch_count),
        .stall_count     (stall_count),
`endif
        .misalign_fault  (misalign_fault)
    );

    instruction_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_wrap (
        .clk             (clk),
        .rst_n           (rst_n2),
        .start           (start2),
        .stall           (1'b0),
        .redirect_en     (1'b0),
        .redirect_target (32'd0),
        .imem_addr       (imem_addr2),
        .imem_data       (imem_data2),
        .if_instr        (if_instr2),
        .if_pc           (if_pc2),
        .if_pc_plus4     (if_pc_plus42),
        .if_valid        (if_valid2),
`ifdef IFETCH_PERF_CNT_EN
        .fetch_count     (fetch_count2),
        .stall_count     (stall_count2),
`endif
        .misalign_fault  (misalign_fault2)
    );

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        fault;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | i;

        //            rst  st  stl red target        addr          instr         pc            pc4           v  f
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h00, 32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,32'h00, 32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
        // IDLE ignores stall/redirect; start moves to RUN
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b1,32'h40, 32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b0,32'h00, 32'h0000_0004,32'h1000_0000,32'h0000_0000,32'h0000_0004,1'b1,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,32'h00, 32'h0000_0008,32'h1000_0001,32'h0000_0004,32'h0000_0008,1'b1,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b1,1'b0,32'h00, 32'h0000_0008,32'h1000_0001,32'h0000_0004,32'h0000_0008,1'b1,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b0,32'h00, 32'h0000_0008,32'h1000_0001,32'h0000_0004,32'h0000_0008,1'b1,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,32'h00, 32'h0000_0008,32'h1000_0001,32'h0000_0004,32'h0000_0008,1'b1,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,32'h00, 32'h0000_000C,32'h1000_0002,32'h0000_0008,32'h0000_000C,1'b1,1'b0};
        // redirect wins over stall
        tbl[9]  = '{1'b1,1'b0,1'b1,1'b1,32'h40, 32'h0000_0040,32'h0000_0000,32'h0000_0008,32'h0000_000C,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,32'h00, 32'h0000_0044,32'h1000_0010,32'h0000_0040,32'h0000_0044,1'b1,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b1,32'h42, 32'h0000_0044,32'h0000_0000,32'h0000_0040,32'h0000_0044,1'b0,1'b1};
        tbl[12] = '{1'b1,1'b1,1'b0,1'b1,32'h80, 32'h0000_0044,32'h0000_0000,32'h0000_0040,32'h0000_0044,1'b0,1'b1};
        tbl[13] = '{1'b1,1'b1,1'b0,1'b0,32'h00, 32'h0000_0044,32'h0000_0000,32'h0000_0040,32'h0000_0044,1'b0,1'b1};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b0,32'h00, 32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
        tbl[15] = '{1'b1,1'b1,1'b0,1'b0,32'h00, 32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_0000,1'b0,1'b0};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b0,32'h00, 32'h0000_0004,32'h1000_0000,32'h0000_0000,32'h0000_0004,1'b1,1'b0};
        tbl[17] = '{1'b1,1'b1,1'b1,1'b0,32'h00, 32'h0000_0004,32'h1000_0000,32'h0000_0000,32'h0000_0004,1'b1,1'b0};
        // mid-run reset while stalled
        tbl[18] = '{1'b0,1'b1,1'b1,1'b0,32'h00, 32'h0000_0000,32'h0000_0000,32'h0000_0000,32'h0000_0000,1'b0,1'b0};

        rst_n = 1'b0; start = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_target = 32'd0;
        rst_n2 = 1'b0; start2 = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst_n           = tbl[i].rst_n;
            start           = tbl[i].start;
            stall           = tbl[i].stall;
            redirect_en     = tbl[i].redir;
            redirect_target = tbl[i].target;
            step();
            chk($sformatf("v%0d imem_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("v%0d if_instr", i), if_instr, tbl[i].instr);
            chk($sformatf("v%0d if_pc", i), if_pc, tbl[i].pc);
            chk($sformatf("v%0d if_pc_plus4", i), if_pc_plus4, tbl[i].pc4);
            chk($sformatf("v%0d if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].valid});
            chk($sformatf("v%0d misalign_fault", i), {31'd0, misalign_fault},
                {31'd0, tbl[i].fault});
`ifdef IFETCH_PERF_CNT_EN
            if (i == 17) begin
                chk("fetch_count before reset", fetch_count, 32'd1);
                chk("stall_count before reset", stall_count, 32'd1);
            end
            if (i == 18) begin
                chk("fetch_count after reset", fetch_count, 32'd0);
                chk("stall_count after reset", stall_count, 32'd0);
            end
`endif
        end

        // PC wrap from 0xFFFF_FFF8 through zero without a fault
        chk("wrap reset addr", imem_addr2, 32'hFFFF_FFF8);
        @(negedge clk);
        rst_n2 = 1'b1; start2 = 1'b1;
        step();
        chk("wrap idle->run addr", imem_addr2, 32'hFFFF_FFF8);
        step();
        chk("wrap f0 instr", if_instr2, 32'h1000_001E);
        chk("wrap f0 pc", if_pc2, 32'hFFFF_FFF8);
        chk("wrap f0 addr", imem_addr2, 32'hFFFF_FFFC);
        step();
        chk("wrap f1 instr", if_instr2, 32'h1000_001F);
        chk("wrap f1 pc", if_pc2, 32'hFFFF_FFFC);
        chk("wrap f1 pc_plus4", if_pc_plus42, 32'h0000_0000);
        chk("wrap f1 addr", imem_addr2, 32'h0000_0000);
        step();
        chk("wrap f2 instr", if_instr2, 32'h1000_0000);
        chk("wrap f2 pc", if_pc2, 32'h0000_0000);
        chk("wrap f2 valid", {31'd0, if_valid2}, 32'd1);
        chk("wrap f2 fault", {31'd0, misalign_fault2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
